// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter.
//   XLEN / REG_ADDR_W : data and register-address widths
//   arb_state_e       : starvation FSM states (IDLE, PENDING, FORCE)
//   fifo_entry_t      : one queued long-unit result {rd, data}
package wb_arb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FORCE   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } fifo_entry_t;
endpackage

// File: rtl/wb_arb_fifo.sv
// Synchronous result FIFO for the writeback arbiter.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, push_entry : write push_entry at the clock edge (ignored when full)
//   pop           : drop the head entry at the clock edge (ignored when empty)
//   head          : current head entry (valid when count != 0)
//   count         : occupancy, 0..DEPTH
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fifo_entry_t              push_entry,
  input  logic                     pop,
  output fifo_entry_t              head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];
  localparam logic [PW:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  fifo_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & (r_count != FULL_CNT);
  assign w_pop  = pop & (r_count != '0);

  // Storage is not reset: entries are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rptr];
  assign count = r_count;
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between the in-order writeback slot and an
// out-of-band long-latency unit. Pipeline writes always win; long-unit results
// queue in a FIFO and drain into idle slots. A starvation FSM raises pipe_stall
// when the queue head has gone undrained for MAX_WAIT consecutive cycles.
// Optional feature macro: WB_ARB_STATS_EN adds stall_cycles (saturating count
// of cycles with pipe_stall=1, cleared by rst).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   pipe_rf_wb, pipe_rd, pipe_data: writeback stage write request
//   lu_valid, lu_ready, lu_rd, lu_data : long-unit result handshake
//   rf_we, rf_waddr, rf_wdata     : register-file write port (combinational)
//   pipe_stall                    : registered bubble request to upstream
//   buf_count                     : FIFO occupancy
//   stall_cycles                  : (WB_ARB_STATS_EN only) stall statistics
//   dbg_state                     : current FSM state (arb_state_e encoding)
//
// Handshake: a long-unit result transfers on the rising edge where
// lu_valid & lu_ready are both 1. lu_ready depends only on occupancy (never
// on lu_valid or on a same-cycle pop); the producer must hold lu_rd/lu_data
// stable while lu_valid=1 and lu_ready=0.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_rf_wb,
  input  logic [REG_ADDR_W-1:0]  pipe_rd,
  input  logic [XLEN-1:0]        pipe_data,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [REG_ADDR_W-1:0]  lu_rd,
  input  logic [XLEN-1:0]        lu_data,
  output logic                   rf_we,
  output logic [REG_ADDR_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic                   pipe_stall,
  output logic [$clog2(DEPTH):0] buf_count,
`ifdef WB_ARB_STATS_EN
  output logic [31:0]            stall_cycles,
`endif
  output logic [1:0]             dbg_state
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT   = DEPTH[CW-1:0];
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    MAX_WAIT_C = MAX_WAIT[7:0];

  arb_state_e    r_state;
  arb_state_e    w_state_next;
  logic [7:0]    r_wait;
  logic [7:0]    w_wait_next;
  logic [7:0]    w_wait_inc;
  logic          r_pipe_stall;

  logic          w_slot_busy;
  logic          w_fifo_nempty;
  logic          w_push;
  logic          w_store;
  logic          w_pop;
  logic          w_last_pop;
  fifo_entry_t   w_head;
  fifo_entry_t   w_push_entry;
  logic [CW-1:0] w_count;

  // A writeback to x0 is a free slot: no write happens, so the queue may use it.
  assign w_slot_busy   = pipe_rf_wb & (pipe_rd != '0);
  assign w_fifo_nempty = (w_count != '0);

  assign lu_ready = (w_count < FULL_CNT) & ~rst;
  assign w_push   = lu_valid & lu_ready;
  // Results for x0 complete the handshake but are never stored.
  assign w_store  = w_push & (lu_rd != '0);
  assign w_pop    = ~rst & ~w_slot_busy & w_fifo_nempty;
  // The queue becomes empty at this edge.
  assign w_last_pop = w_pop & ~w_store & (w_count == CNT_ONE);

  assign w_push_entry = '{rd: lu_rd, data: lu_data};

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_store),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .count      (w_count)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (w_slot_busy) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_data;
      end else if (w_fifo_nempty) begin
        rf_we    = 1'b1;
        rf_waddr = w_head.rd;
        rf_wdata = w_head.data;
      end
    end
  end

  assign w_wait_inc = r_wait + 8'd1;

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    case (r_state)
      IDLE: begin
        w_wait_next = '0;
        if (w_store) w_state_next = PENDING;
      end
      PENDING: begin
        if (w_pop) begin
          w_wait_next = '0;
          if (w_last_pop) w_state_next = IDLE;
        end else begin
          w_wait_next = w_wait_inc;
          if (w_wait_inc == MAX_WAIT_C) w_state_next = FORCE;
        end
      end
      FORCE: begin
        // Only a drained head releases the stall; a busy pipe slot keeps it.
        if (w_pop) begin
          w_wait_next  = '0;
          w_state_next = w_last_pop ? IDLE : PENDING;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_wait_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wait       <= '0;
      r_pipe_stall <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wait       <= w_wait_next;
      r_pipe_stall <= (w_state_next == FORCE);
    end
  end

  assign pipe_stall = r_pipe_stall;
  assign buf_count  = w_count;
  assign dbg_state  = r_state;

`ifdef WB_ARB_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (r_pipe_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pipe_rf_wb;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [1:0]  buf_count;
  logic [1:0]  dbg_state;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stall_cycles;
`endif

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_rf_wb   (pipe_rf_wb),
    .pipe_rd      (pipe_rd),
    .pipe_data    (pipe_data),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_rd        (lu_rd),
    .lu_data      (lu_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pipe_stall   (pipe_stall),
    .buf_count    (buf_count),
`ifdef WB_ARB_STATS_EN
    .stall_cycles (stall_cycles),
`endif
    .dbg_state    (dbg_state)
  );

  // scoreboard / reference model: queued results as {rd, data}
  logic [36:0] exp_q[$];
  int          m_wait;       // consecutive cycles the current head went undrained
  bit          m_force;      // a bubble is being requested
  logic [31:0] m_stall_cnt;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Compare every output against the model at mid-cycle, then advance the
  // model by the rules for the inputs of this cycle and step one clock.
  task automatic tick();
    bit          busy;
    bit          pop;
    bit          push;
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [36:0] hd;
    int          sz;
    @(negedge clk);
    sz       = exp_q.size();
    busy     = pipe_rf_wb && (pipe_rd != 5'd0);
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    if (!rst) begin
      if (busy) begin
        exp_we = 1'b1; exp_addr = pipe_rd; exp_data = pipe_data;
      end else if (sz > 0) begin
        hd = exp_q[0];
        exp_we = 1'b1; exp_addr = hd[36:32]; exp_data = hd[31:0];
      end
    end
    chk("rf_we", 64'(rf_we), 64'(exp_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(exp_addr));
    chk("rf_wdata", 64'(rf_wdata), 64'(exp_data));
    chk("lu_ready", 64'(lu_ready), 64'(!rst && sz < DEPTH));
    chk("pipe_stall", 64'(pipe_stall), 64'(m_force));
    chk("buf_count", 64'(buf_count), 64'(sz));
    chk("fsm_state", 64'(dbg_state), 64'(m_force ? 2 : (sz > 0 ? 1 : 0)));
`ifdef WB_ARB_STATS_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall_cnt));
`endif
    push = !rst && lu_valid && (sz < DEPTH) && (lu_rd != 5'd0);
    pop  = !rst && !busy && (sz > 0);
    if (rst) begin
      exp_q.delete();
      m_wait = 0; m_force = 0; m_stall_cnt = '0;
    end else begin
      if (m_force && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (pop) begin
        void'(exp_q.pop_front());
        m_wait = 0; m_force = 0;
      end else if (sz > 0 && !m_force) begin
        m_wait++;
        if (m_wait == MAX_WAIT) m_force = 1;
      end
      if (push) exp_q.push_back({lu_rd, lu_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wb, input logic [4:0] prd, input bit lv, input logic [4:0] lrd,
                       input logic [31:0] ldata);
    pipe_rf_wb = wb;
    pipe_rd    = prd;
    pipe_data  = $urandom;
    lu_valid   = lv;
    lu_rd      = lrd;
    lu_data    = ldata;
  endtask

  initial begin
    int n;
    m_wait = 0; m_force = 0; m_stall_cnt = '0;
    rst = 1'b1;
    drive(0, 5'd0, 1, 5'd5, 32'h1111_1111);
    @(posedge clk); #1;

    // 1: reset holds off everything
    for (int i = 0; i < 3; i++) begin
      chk("t1_lu_ready", 64'(lu_ready), 64'(0));
      chk("t1_rf_we", 64'(rf_we), 64'(0));
      chk("t1_stall", 64'(pipe_stall), 64'(0));
      tick();
    end
    rst = 1'b0;
    drive(0, 5'd0, 0, 5'd0, 32'h0);
    #1 chk("t1_count", 64'(buf_count), 64'(0));
    tick();

    // 2: single push drains next cycle, not the same one
    drive(0, 5'd0, 1, 5'd5, 32'hDEAD_BEEF);
    #1 chk("t2_no_bypass", 64'(rf_we), 64'(0));
    tick();
    lu_valid = 0;
    #1 chk("t2_we", 64'(rf_we), 64'(1));
    chk("t2_waddr", 64'(rf_waddr), 64'(5));
    chk("t2_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
    tick();
    chk("t2_count", 64'(buf_count), 64'(0));

    // 3: starvation forces a bubble
    drive(1, 5'd3, 1, 5'd7, 32'h7777_0007);
    tick();
    lu_valid = 0;
    n = 0;
    while (!pipe_stall && n < 20) begin
      #1 chk("t3_pipe_wins", 64'(rf_waddr), 64'(3));
      tick();
      n++;
    end
    chk("t3_wait_cycles", 64'(n), 64'(MAX_WAIT));
    chk("t3_stall_set", 64'(pipe_stall), 64'(1));
    #1 chk("t3_force_pipe_wins", 64'(rf_waddr), 64'(3));
    tick();
    chk("t3_stall_held", 64'(pipe_stall), 64'(1));
    pipe_rf_wb = 0;
    #1 chk("t3_drain_addr", 64'(rf_waddr), 64'(7));
    chk("t3_drain_data", 64'(rf_wdata), 64'(32'h7777_0007));
    tick();
    chk("t3_stall_clr", 64'(pipe_stall), 64'(0));
    chk("t3_idle", 64'(dbg_state), 64'(0));

    // 4: full FIFO back-pressures, strict order
    drive(1, 5'd3, 1, 5'd1, 32'h0000_0001);
    tick();
    drive(1, 5'd3, 1, 5'd2, 32'h0000_0002);
    tick();
    drive(1, 5'd3, 1, 5'd4, 32'h0000_0004);
    #1 chk("t4_count_full", 64'(buf_count), 64'(2));
    chk("t4_not_ready", 64'(lu_ready), 64'(0));
    tick();
    pipe_rf_wb = 0;
    #1 chk("t4_w1", 64'(rf_waddr), 64'(1));
    chk("t4_no_popthrough", 64'(lu_ready), 64'(0));
    tick();
    #1 chk("t4_w2", 64'(rf_waddr), 64'(2));
    tick();
    lu_valid = 0;
    #1 chk("t4_w4", 64'(rf_waddr), 64'(4));
    tick();
    chk("t4_empty_we", 64'(rf_we), 64'(0));

    // 5: write to x0 frees the slot; push to x0 stores nothing
    drive(0, 5'd0, 1, 5'd9, 32'h9999_0009);
    tick();
    drive(1, 5'd0, 0, 5'd0, 32'h0);
    #1 chk("t5_free_slot_addr", 64'(rf_waddr), 64'(9));
    tick();
    drive(1, 5'd0, 1, 5'd0, 32'hABCD_0000);
    #1 chk("t5_rd0_ready", 64'(lu_ready), 64'(1));
    tick();
    lu_valid = 0;
    #1 chk("t5_rd0_count", 64'(buf_count), 64'(0));
    chk("t5_rd0_we", 64'(rf_we), 64'(0));
    tick();

    // 6: reset discards queued results
    drive(1, 5'd3, 1, 5'd10, 32'h0000_000A);
    tick();
    drive(1, 5'd3, 1, 5'd11, 32'h0000_000B);
    tick();
    lu_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    pipe_rf_wb = 0;
    #1 chk("t6_count", 64'(buf_count), 64'(0));
    chk("t6_we", 64'(rf_we), 64'(0));
`ifdef WB_ARB_STATS_EN
    chk("t6_stats", 64'(stall_cycles), 64'(0));
`endif
    tick();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      bit wb;
      wb = ($urandom_range(0, 99) < ((i < 400) ? 85 : 40));
      if (pipe_stall && $urandom_range(0, 3) != 0) wb = 0;
      drive(wb, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
